// File: rtl/sonic_vc_packet_arbiter.sv
// Packet-atomic arbiter merging two streaming sources onto one registered output.
// Alternates grants on contention and discards orphan (non-SOP) beats while idle.
module sonic_vc_packet_arbiter #(
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned EMPTY_W = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in0_valid,
  output logic               in0_ready,
  input  logic [DATA_W-1:0]  in0_data,
  input  logic               in0_error,
  input  logic               in0_startofpacket,
  input  logic               in0_endofpacket,
  input  logic [EMPTY_W-1:0] in0_empty,
  input  logic               in1_valid,
  output logic               in1_ready,
  input  logic [DATA_W-1:0]  in1_data,
  input  logic               in1_error,
  input  logic               in1_startofpacket,
  input  logic               in1_endofpacket,
  input  logic [EMPTY_W-1:0] in1_empty,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_error,
  output logic               out_startofpacket,
  output logic               out_endofpacket,
  output logic [EMPTY_W-1:0] out_empty,
  output logic               out_channel,
  output logic [15:0]        drop_count
);

  localparam int unsigned      CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic               grant_q, grant_d;
  logic               last_grant_q, last_grant_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               out_error_q, out_error_d;
  logic               out_sop_q, out_sop_d;
  logic               out_eop_q, out_eop_d;
  logic [EMPTY_W-1:0] out_empty_q, out_empty_d;
  logic               out_channel_q, out_channel_d;
  logic [CNT_W-1:0]   drop_count_q, drop_count_d;

  logic               req0, req1, drop0, drop1;
  logic               out_free, accept;
  logic [CNT_W:0]     drop_sum;
  logic               sel_valid, sel_error, sel_sop, sel_eop;
  logic [DATA_W-1:0]  sel_data;
  logic [EMPTY_W-1:0] sel_empty;

  assign req0     = in0_valid && in0_startofpacket;
  assign req1     = in1_valid && in1_startofpacket;
  assign drop0    = in0_valid && !in0_startofpacket;
  assign drop1    = in1_valid && !in1_startofpacket;
  assign out_free = !out_valid_q || out_ready;
  assign drop_sum = {1'b0, drop_count_q} + (CNT_W+1)'(drop0) + (CNT_W+1)'(drop1);

  // Beat of the currently granted source
  assign sel_valid = grant_q ? in1_valid         : in0_valid;
  assign sel_data  = grant_q ? in1_data          : in0_data;
  assign sel_error = grant_q ? in1_error         : in0_error;
  assign sel_sop   = grant_q ? in1_startofpacket : in0_startofpacket;
  assign sel_eop   = grant_q ? in1_endofpacket   : in0_endofpacket;
  assign sel_empty = grant_q ? in1_empty         : in0_empty;
  assign accept    = (state_q == ST_BUSY) && sel_valid && out_free;

  // Ready: drain orphans while idle, follow output register space while busy
  always_comb begin
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    if (reset_n) begin
      if (state_q == ST_IDLE) begin
        in0_ready = drop0;
        in1_ready = drop1;
      end else begin
        in0_ready = !grant_q && out_free;
        in1_ready = grant_q && out_free;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_error_d   = out_error_q;
    out_sop_d     = out_sop_q;
    out_eop_d     = out_eop_q;
    out_empty_d   = out_empty_q;
    out_channel_d = out_channel_q;
    drop_count_d  = drop_count_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (state_q == ST_IDLE) begin
      drop_count_d = drop_sum[CNT_W] ? CNT_MAX : drop_sum[CNT_W-1:0];
      if (req0 || req1) begin
        // On a tie the source that did not win last time gets the grant
        grant_d = (req0 && req1) ? !last_grant_q : req1;
        state_d = ST_BUSY;
      end
    end else if (accept) begin
      out_valid_d   = 1'b1;
      out_data_d    = sel_data;
      out_error_d   = sel_error;
      out_sop_d     = sel_sop;
      out_eop_d     = sel_eop;
      out_empty_d   = sel_empty;
      out_channel_d = grant_q;
      if (sel_eop) begin
        state_d      = ST_IDLE;
        last_grant_d = grant_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      grant_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_error_q   <= 1'b0;
      out_sop_q     <= 1'b0;
      out_eop_q     <= 1'b0;
      out_empty_q   <= '0;
      out_channel_q <= 1'b0;
      drop_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_error_q   <= out_error_d;
      out_sop_q     <= out_sop_d;
      out_eop_q     <= out_eop_d;
      out_empty_q   <= out_empty_d;
      out_channel_q <= out_channel_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign out_valid         = out_valid_q;
  assign out_data          = out_data_q;
  assign out_error         = out_error_q;
  assign out_startofpacket = out_sop_q;
  assign out_endofpacket   = out_eop_q;
  assign out_empty         = out_empty_q;
  assign out_channel       = out_channel_q;
  assign drop_count        = drop_count_q;

endmodule

// File: tb/tb_sonic_vc_packet_arbiter.sv
// Bench for sonic_vc_packet_arbiter: queued packet sources, a transaction-level
// arbitration model and an order-checking scoreboard, directed scenarios then random traffic.
module tb_sonic_vc_packet_arbiter;

  localparam int unsigned DW = 128;
  localparam int unsigned EW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          err;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in0_valid, in0_ready, in0_error, in0_startofpacket, in0_endofpacket;
  logic [DW-1:0] in0_data;
  logic [EW-1:0] in0_empty;
  logic          in1_valid, in1_ready, in1_error, in1_startofpacket, in1_endofpacket;
  logic [DW-1:0] in1_data;
  logic [EW-1:0] in1_empty;
  logic          out_ready, out_valid, out_error, out_startofpacket, out_endofpacket, out_channel;
  logic [DW-1:0] out_data;
  logic [EW-1:0] out_empty;
  logic [15:0]   drop_count;

  always #5 clk = ~clk;

  sonic_vc_packet_arbiter #(.DATA_W(DW), .EMPTY_W(EW)) dut (
    .clk(clk), .reset_n(reset_n),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_data(in0_data), .in0_error(in0_error),
    .in0_startofpacket(in0_startofpacket), .in0_endofpacket(in0_endofpacket), .in0_empty(in0_empty),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data), .in1_error(in1_error),
    .in1_startofpacket(in1_startofpacket), .in1_endofpacket(in1_endofpacket), .in1_empty(in1_empty),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .out_error(out_error),
    .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket), .out_empty(out_empty),
    .out_channel(out_channel), .drop_count(drop_count)
  );

  beat_t src_q [2][$];
  beat_t exp_q [2][$];
  logic  drv_v [2];
  beat_t drv_b [2];
  logic  e_rdy [2];
  int    acc_cnt [2];
  int    chan_log[$];
  int    step_log[$];

  int    n_cmp = 0, n_bad = 0;
  int    known = 0, pstep = 0, pkt_id = 0, orphans = 0;
  int    bubble_en = 0, orm = 0;
  bit    tog = 1'b0;

  // Transaction-level model: owner (-1 = nobody), last winner, held output beat, drop tally
  int    m_owner = -1, m_last = 1, m_hv = 0, m_chan = 0, m_drops = 0;
  beat_t m_hold = '0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void chk_beat(string name, beat_t act, beat_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic beat_t mk(int k, int p, int i, bit sop, bit eop);
    beat_t b;
    b.data  = {32'(k), 32'(p), 32'(i), 32'($urandom())};
    b.err   = 1'($urandom_range(0, 1));
    b.sop   = sop;
    b.eop   = eop;
    b.empty = EW'($urandom());
    return b;
  endfunction

  task automatic add_packet(int k, int len, bit midsop);
    for (int i = 0; i < len; i++) begin
      src_q[k].push_back(mk(k, pkt_id, i, (i == 0) || (midsop && $urandom_range(0, 3) == 0),
                            i == len - 1));
    end
    pkt_id++;
  endtask

  task automatic add_orphans(int k, int n);
    for (int i = 0; i < n; i++) begin
      src_q[k].push_back(mk(k, pkt_id, i, 1'b0, 1'($urandom_range(0, 1))));
    end
    orphans += n;
    pkt_id++;
  endtask

  function automatic logic model_ready(int k);
    if (!reset_n) return 1'b0;
    if (m_owner < 0) return drv_v[k] && !drv_b[k].sop;
    return (k == m_owner) && (m_hv == 0 || out_ready);
  endfunction

  task automatic drive_inputs();
    for (int k = 0; k < 2; k++) begin
      drv_v[k] = (src_q[k].size() > 0) && (bubble_en == 0 || $urandom_range(0, 3) != 0);
      drv_b[k] = (src_q[k].size() > 0) ? src_q[k][0] : '0;
    end
    in0_valid = drv_v[0]; in0_data = drv_b[0].data; in0_error = drv_b[0].err;
    in0_startofpacket = drv_b[0].sop; in0_endofpacket = drv_b[0].eop; in0_empty = drv_b[0].empty;
    in1_valid = drv_v[1]; in1_data = drv_b[1].data; in1_error = drv_b[1].err;
    in1_startofpacket = drv_b[1].sop; in1_endofpacket = drv_b[1].eop; in1_empty = drv_b[1].empty;
    case (orm)
      0:       out_ready = 1'b1;
      1:       begin out_ready = !tog; tog = !tog; end
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic check_cycle();
    for (int k = 0; k < 2; k++) e_rdy[k] = model_ready(k);
    chk("in0_ready", 64'(in0_ready), 64'(e_rdy[0]));
    chk("in1_ready", 64'(in1_ready), 64'(e_rdy[1]));
    if (known != 0) begin
      chk("out_valid", 64'(out_valid), 64'(m_hv));
      if (m_hv != 0) begin
        chk_beat("out_beat", {out_data, out_error, out_startofpacket, out_endofpacket, out_empty}, m_hold);
        chk("out_channel", 64'(out_channel), 64'(m_chan));
      end
      chk("drop_count", 64'(drop_count), 64'(m_drops));
    end
  endtask

  task automatic observe();
    beat_t ob;
    int    ch;
    if (known != 0 && out_valid && out_ready) begin
      ob = {out_data, out_error, out_startofpacket, out_endofpacket, out_empty};
      ch = int'(out_channel);
      chan_log.push_back(ch);
      step_log.push_back(pstep);
      if (exp_q[ch].size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb_extra_beat: channel %0d delivered %0h, required no beat", ch, ob);
      end else begin
        chk_beat("sb_order", ob, exp_q[ch].pop_front());
      end
    end
    if (drv_v[0] && in0_ready) begin void'(src_q[0].pop_front()); acc_cnt[0]++; end
    if (drv_v[1] && in1_ready) begin void'(src_q[1].pop_front()); acc_cnt[1]++; end
  endtask

  task automatic model_next();
    bit req0, req1;
    if (!reset_n) begin
      m_owner = -1; m_last = 1; m_hv = 0; m_hold = '0; m_chan = 0; m_drops = 0; known = 1;
      exp_q[0].delete(); exp_q[1].delete();
      return;
    end
    if (m_hv != 0 && out_ready) m_hv = 0;
    if (m_owner < 0) begin
      for (int k = 0; k < 2; k++) begin
        if (drv_v[k] && !drv_b[k].sop && m_drops < 65535) m_drops++;
      end
      req0 = drv_v[0] && drv_b[0].sop;
      req1 = drv_v[1] && drv_b[1].sop;
      if (req0 && req1) m_owner = 1 - m_last;
      else if (req0)    m_owner = 0;
      else if (req1)    m_owner = 1;
    end else if (drv_v[m_owner] && e_rdy[m_owner]) begin
      m_hold = drv_b[m_owner];
      m_chan = m_owner;
      m_hv   = 1;
      exp_q[m_owner].push_back(drv_b[m_owner]);
      if (drv_b[m_owner].eop) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end
  endtask

  task automatic step();
    drive_inputs();
    @(negedge clk);
    check_cycle();
    observe();
    model_next();
    @(posedge clk);
    #1;
    pstep++;
  endtask

  task automatic run_until_idle(int budget);
    int n = 0;
    while (!(src_q[0].size() == 0 && src_q[1].size() == 0 && exp_q[0].size() == 0 &&
             exp_q[1].size() == 0 && m_hv == 0 && m_owner < 0)) begin
      if (n >= budget) begin
        n_cmp++; n_bad++;
        $display("FAIL drain_timeout: traffic pending after %0d cycles, required idle", budget);
        return;
      end
      step();
      n++;
    end
    step();
    step();
  endtask

  task automatic new_phase();
    chan_log.delete();
    step_log.delete();
    acc_cnt[0] = 0;
    acc_cnt[1] = 0;
    pstep = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pat[7];
    int n;
    pat = '{1, 0, 1, 0, 1, 0, 1};
    reset_n = 1'b0;
    drv_v[0] = 1'b0; drv_v[1] = 1'b0; drv_b[0] = '0; drv_b[1] = '0;
    drive_inputs();
    @(posedge clk);
    #1;

    // Reset with both sources already offering SOP: readies must stay low
    add_packet(0, 3, 1'b0);
    add_packet(1, 3, 1'b0);
    step();
    step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_drop_count", 64'(drop_count), 64'd0);
    chk("rst_out_channel", 64'(out_channel), 64'd0);
    chk("rst_out_data", out_data[63:0] | out_data[127:64], 64'd0);
    chk("rst_out_side", 64'({out_error, out_startofpacket, out_endofpacket, out_empty}), 64'd0);

    // First tie after reset goes to source 0, whole packet before source 1
    reset_n = 1'b1;
    new_phase();
    run_until_idle(100);
    chk("tie_count", 64'(chan_log.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < chan_log.size()) chk("tie_chan", 64'(chan_log[i]), 64'(i / 3));
    end

    // Orphan beats in idle are swallowed and counted
    new_phase();
    add_orphans(1, 5);
    run_until_idle(100);
    chk("orphan_drops", 64'(drop_count), 64'd5);
    chk("orphan_no_output", 64'(chan_log.size()), 64'd0);

    // Single-beat packets: arbitrate + transfer, channels alternate
    new_phase();
    for (int i = 0; i < 3; i++) begin
      add_packet(0, 1, 1'b0);
      add_packet(1, 1, 1'b0);
    end
    run_until_idle(100);
    chk("single_count", 64'(chan_log.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < chan_log.size()) begin
        chk("single_chan", 64'(chan_log[i]), 64'(i % 2));
        chk("single_step", 64'(step_log[i]), 64'(2 * i + 2));
      end
    end

    // Backpressure toggling during an 8-beat packet
    new_phase();
    orm = 1;
    add_packet(0, 8, 1'b0);
    run_until_idle(100);
    chk("toggle_count", 64'(chan_log.size()), 64'd8);
    orm = 0;

    // Continuous contention: whole packets alternate between sources
    new_phase();
    for (int i = 0; i < 3; i++) add_packet(0, 4, 1'b0);
    for (int i = 0; i < 4; i++) add_packet(1, 4, 1'b0);
    run_until_idle(200);
    chk("alt_count", 64'(chan_log.size()), 64'd28);
    for (int i = 0; i < 28; i++) begin
      if (i < chan_log.size()) chk("alt_chan", 64'(chan_log[i]), 64'(pat[i / 4]));
    end

    // Reset pulse mid-packet abandons it; the tail is dropped from a zero count
    new_phase();
    add_packet(0, 6, 1'b0);
    n = 0;
    while (acc_cnt[0] < 3 && n < 50) begin
      step();
      n++;
    end
    if (acc_cnt[0] < 3) begin
      n_cmp++; n_bad++;
      $display("FAIL midrst_accept: %0d beats accepted, required 3", acc_cnt[0]);
    end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_drops_zero", 64'(drop_count), 64'd0);
    run_until_idle(50);
    chk("midrst_drops", 64'(drop_count), 64'd3);

    // Random traffic with bubbles, backpressure, mid-packet SOPs and orphans
    new_phase();
    orphans = 0;
    bubble_en = 1;
    orm = 2;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (src_q[k].size() < 8 && $urandom_range(0, 9) == 0) begin
          if ($urandom_range(0, 7) == 0) add_orphans(k, $urandom_range(1, 3));
          else add_packet(k, $urandom_range(1, 6), 1'b1);
        end
      end
      step();
    end
    run_until_idle(3000);
    chk("rand_drops", 64'(drop_count), 64'(3 + orphans));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sonic_vc_packet_arbiter.md
SONIC_VC_PACKET_ARBITER -- requirements
Module: sonic_vc_packet_arbiter

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 Parameter DATA_W, default 128, SHALL set the data width of all streaming ports.
REQ-003 Parameter EMPTY_W, default 2, SHALL set the empty-field width of all streaming ports.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-006 inN_valid  input  1  source N (N=0,1) beat valid.
REQ-007 inN_ready  output  1  source N beat accepted when inN_valid && inN_ready.
REQ-008 inN_data  input  DATA_W  source N payload.
REQ-009 inN_error, inN_startofpacket, inN_endofpacket  input  1 each  source N sideband.
REQ-010 inN_empty  input  EMPTY_W  source N empty bytes on EOP beat.
REQ-011 out_ready  input  1  downstream (VC multiplexer adapter) ready.
REQ-012 out_valid  output  1  registered beat valid.
REQ-013 out_data, out_error, out_startofpacket, out_endofpacket, out_empty  output  DATA_W/1/1/1/EMPTY_W  registered payload.
REQ-014 out_channel  output  1  index of source that produced the current out beat.
REQ-015 drop_count  output  16  saturating count of beats discarded in IDLE.

Function
REQ-016 Arbiter SHALL be packet-atomic: states IDLE and BUSY, plus a grant register (1 bit) and last_grant register (1 bit).
REQ-017 IDLE: a request is inN_valid && inN_startofpacket; one request -> grant that source; both -> grant the source != last_grant; next state BUSY; no beat accepted in the arbitration cycle.
REQ-018 IDLE: a source with inN_valid && !inN_startofpacket SHALL see inN_ready=1, its beat is discarded, drop_count increments (saturating at 0xFFFF); requests take priority: a source granted this cycle is not drained.
REQ-019 BUSY: in[grant]_ready = !out_valid || out_ready (combinational); the other source's ready = 0.
REQ-020 Output register SHALL load the granted beat and out_channel=grant on acceptance; out_valid holds with payload stable until out_ready; latency input-accept to out_valid = 1 cycle.
REQ-021 Accepted beat with endofpacket in BUSY -> next state IDLE, last_grant <= grant; minimum gap between packet starts = 1 idle cycle.
REQ-022 Single-beat packet (SOP and EOP same beat) SHALL be handled as REQ-021.
REQ-023 SOP received mid-packet in BUSY SHALL be forwarded unchanged; packet ends only on EOP.
REQ-024 Output register with out_valid=1 and out_ready=1 and no new beat -> out_valid <= 0 next cycle.
REQ-025 Full throughput: with out_ready held 1, one beat per cycle SHALL transfer in BUSY.

Reset
REQ-026 reset_n=0 SHALL force: state IDLE, out_valid 0, out_channel 0, all out payload 0, last_grant 1 (source 0 wins first tie), grant 0, drop_count 0, all inN_ready 0 during reset.
REQ-027 Reset asserted mid-packet SHALL abandon the packet; after release the arbiter restarts in IDLE and requires a fresh SOP.

Verification
REQ-028 Both sources present SOP at cycle 0 after reset -> source 0 granted, out_channel=0 for its whole packet; then source 1 granted, out_channel=1.
REQ-029 Source 0 sends three 4-beat packets while source 1 continuously requests -> grants alternate 0,1,0,1,...; no beat interleaving within a packet.
REQ-030 out_ready toggled 1010... during 8-beat packet -> out payload stable while out_valid && !out_ready; all 8 beats delivered in order, none duplicated.
REQ-031 Source 1 drives 5 valid beats without SOP while IDLE and source 0 idle -> all accepted and discarded, out_valid stays 0, drop_count = 5.
REQ-032 reset_n low for 1 cycle at beat 3 of a 6-beat packet -> out_valid 0 next cycle, state IDLE, remaining non-SOP beats dropped and counted from 0.
REQ-033 Single-beat packets on both sources back-to-back, out_ready=1 -> each packet takes 2 cycles (arbitrate + transfer), channels alternate.
